// File: rtl/conv_window_scheduler.sv
// Steps the convolution window over one output feature map with one window in flight,
// and writes each downstream MAC result to the result memory in row-major order.
//
// state | meaning
// IDLE  | waiting for start
// SETUP | anchors and conv_en applied, window buffer output settling
// ISSUE | window presented downstream (win_valid)
// WAIT  | window accepted, waiting for the scalar result
// WRITE | result written, counters and anchors advanced
// DONE  | one-cycle completion pulse
module conv_window_scheduler #(
    parameter int data_width    = 16,
    parameter int image_length  = 4,
    parameter int image_width   = 4,
    parameter int weight_length = 3,
    parameter int weight_width  = 3,
    parameter int stride        = 1,
    parameter int padding       = 0,
    parameter int result_length = (image_length + 2 * padding - weight_length) / stride + 1,
    parameter int result_width  = (image_width + 2 * padding - weight_width) / stride + 1,
    parameter int addr_width    = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    output logic                  conv_en,
    output logic [data_width-1:0] anchor_2D,
    output logic [data_width-1:0] anchor_1D,
    output logic                  win_valid,
    input  logic                  win_ready,
    input  logic                  res_valid,
    input  logic [data_width-1:0] res_data,
    output logic                  res_wr_en,
    output logic [addr_width-1:0] res_addr,
    output logic [data_width-1:0] res_wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  protocol_err
);

    typedef enum logic [2:0] {IDLE, SETUP, ISSUE, WAIT, WRITE, DONE} state_t;

    localparam logic [addr_width-1:0] last_col    = addr_width'(result_length - 1);
    localparam logic [addr_width-1:0] last_row    = addr_width'(result_width - 1);
    localparam logic [data_width-1:0] stride_step = data_width'(stride);
    localparam longint anchor_span = longint'(result_width - 1) * longint'(stride);

    state_t                state;
    logic [addr_width-1:0] row;
    logic [addr_width-1:0] col;
    logic [addr_width-1:0] addr_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            row          <= '0;
            col          <= '0;
            addr_cnt     <= '0;
            conv_en      <= 1'b0;
            anchor_2D    <= '0;
            anchor_1D    <= '0;
            win_valid    <= 1'b0;
            res_wr_en    <= 1'b0;
            res_addr     <= '0;
            res_wdata    <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            protocol_err <= 1'b0;
        end else if (abort && state != IDLE) begin
            // a WRITE cycle has already strobed its write by the time abort is sampled
            state        <= IDLE;
            row          <= '0;
            col          <= '0;
            addr_cnt     <= '0;
            conv_en      <= 1'b0;
            anchor_2D    <= '0;
            anchor_1D    <= '0;
            win_valid    <= 1'b0;
            res_wr_en    <= 1'b0;
            res_addr     <= '0;
            res_wdata    <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            protocol_err <= 1'b0;
        end else begin
            done      <= 1'b0;
            res_wr_en <= 1'b0;
            if (res_valid && state != WAIT) begin
                protocol_err <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        state        <= SETUP;
                        row          <= '0;
                        col          <= '0;
                        addr_cnt     <= '0;
                        anchor_2D    <= '0;
                        anchor_1D    <= '0;
                        protocol_err <= 1'b0;
                        busy         <= 1'b1;
                        conv_en      <= 1'b1;
                    end
                end
                SETUP: begin
                    state     <= ISSUE;
                    win_valid <= 1'b1;
                end
                ISSUE: begin
                    if (win_ready) begin
                        state     <= WAIT;
                        win_valid <= 1'b0;
                    end
                end
                WAIT: begin
                    if (res_valid) begin
                        state     <= WRITE;
                        res_wr_en <= 1'b1;
                        res_addr  <= addr_cnt;
                        res_wdata <= res_data;
                    end
                end
                WRITE: begin
                    res_addr  <= '0;
                    res_wdata <= '0;
                    addr_cnt  <= addr_cnt + 1'b1;
                    if (row == last_row && col == last_col) begin
                        state     <= DONE;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        conv_en   <= 1'b0;
                        row       <= '0;
                        col       <= '0;
                        anchor_2D <= '0;
                        anchor_1D <= '0;
                    end else begin
                        state <= SETUP;
                        // anchors track col*stride / row*stride by accumulation
                        if (col == last_col) begin
                            col       <= '0;
                            anchor_1D <= '0;
                            row       <= row + 1'b1;
                            anchor_2D <= anchor_2D + stride_step;
                        end else begin
                            col       <= col + 1'b1;
                            anchor_1D <= anchor_1D + stride_step;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    anchor_range: assert property (@(posedge clk) anchor_span < (longint'(1) << data_width));

    win_hold: assert property (@(posedge clk) disable iff (reset)
        (win_valid && !win_ready && !abort) |=> win_valid);

endmodule

// File: tb/tb_conv_window_scheduler.sv
// Scoreboard bench for conv_window_scheduler: default, padded and strided instances.
module tb_conv_window_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start, abort, win_ready, res_valid;
    logic [15:0] res_data, data_base;
    logic        conv_en, win_valid, res_wr_en, busy, done, protocol_err;
    logic [15:0] anchor_2D, anchor_1D, res_wdata;
    logic [7:0]  res_addr;

    logic        start_p, conv_en_p, win_valid_p, res_wr_en_p, busy_p, done_p, perr_p;
    logic [15:0] a2_p, a1_p, wdata_p, rdata_p;
    logic [7:0]  addr_p, last_addr_p;

    logic        start_s, conv_en_s, win_valid_s, res_wr_en_s, busy_s, done_s, perr_s;
    logic [15:0] a2_s, a1_s, wdata_s, rdata_s;
    logic [7:0]  addr_s;

    int errors = 0;
    int checks = 0;
    int wr_count = 0;

    logic [23:0] exp_q[$];
    logic [23:0] exp_qp[$];
    logic [23:0] exp_qs[$];
    logic [31:0] anc_q[$];

    // downstream models: the default map has result_length 2, so addr = 2*row + col
    assign res_data = data_base + (anchor_2D << 1) + anchor_1D;
    assign rdata_p  = {a2_p[7:0], a1_p[7:0]};
    assign rdata_s  = {a2_s[7:0], a1_s[7:0]};

    conv_window_scheduler u_dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .conv_en(conv_en), .anchor_2D(anchor_2D), .anchor_1D(anchor_1D),
        .win_valid(win_valid), .win_ready(win_ready),
        .res_valid(res_valid), .res_data(res_data),
        .res_wr_en(res_wr_en), .res_addr(res_addr), .res_wdata(res_wdata),
        .busy(busy), .done(done), .protocol_err(protocol_err)
    );

    conv_window_scheduler #(.padding(1)) u_pad (
        .clk(clk), .reset(reset), .start(start_p), .abort(1'b0),
        .conv_en(conv_en_p), .anchor_2D(a2_p), .anchor_1D(a1_p),
        .win_valid(win_valid_p), .win_ready(1'b1),
        .res_valid(1'b1), .res_data(rdata_p),
        .res_wr_en(res_wr_en_p), .res_addr(addr_p), .res_wdata(wdata_p),
        .busy(busy_p), .done(done_p), .protocol_err(perr_p)
    );

    conv_window_scheduler #(.image_length(5), .image_width(5), .stride(2)) u_str (
        .clk(clk), .reset(reset), .start(start_s), .abort(1'b0),
        .conv_en(conv_en_s), .anchor_2D(a2_s), .anchor_1D(a1_s),
        .win_valid(win_valid_s), .win_ready(1'b1),
        .res_valid(1'b1), .res_data(rdata_s),
        .res_wr_en(res_wr_en_s), .res_addr(addr_s), .res_wdata(wdata_s),
        .busy(busy_s), .done(done_s), .protocol_err(perr_s)
    );

    // inputs change on the falling edge; #1 later they hold the values the next rising edge sees
    always @(negedge clk) begin
        logic [23:0] e;
        #1;
        if (res_wr_en === 1'b1) begin
            wr_count++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL write_unexpected: got addr=%0d data=%h, required no write", res_addr, res_wdata);
            end else begin
                e = exp_q.pop_front();
                if ({res_addr, res_wdata} !== e) begin
                    errors++;
                    $display("FAIL write: got addr=%0d data=%h, required addr=%0d data=%h",
                             res_addr, res_wdata, e[23:16], e[15:0]);
                end
            end
        end
        if (win_valid === 1'b1) begin
            checks++;
            if (anc_q.size() == 0) begin
                errors++;
                $display("FAIL window_unexpected: got anchors (%0d,%0d), required no window", anchor_2D, anchor_1D);
            end else begin
                if ({anchor_2D, anchor_1D} !== anc_q[0]) begin
                    errors++;
                    $display("FAIL anchors: got (%0d,%0d), required (%0d,%0d)",
                             anchor_2D, anchor_1D, anc_q[0][31:16], anc_q[0][15:0]);
                end
                if (win_ready === 1'b1) void'(anc_q.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        logic [23:0] e;
        #1;
        if (res_wr_en_p === 1'b1) begin
            checks++;
            last_addr_p = addr_p;
            if (exp_qp.size() == 0) begin
                errors++;
                $display("FAIL pad_write_unexpected: got addr=%0d data=%h, required no write", addr_p, wdata_p);
            end else begin
                e = exp_qp.pop_front();
                if ({addr_p, wdata_p} !== e) begin
                    errors++;
                    $display("FAIL pad_write: got addr=%0d data=%h, required addr=%0d data=%h",
                             addr_p, wdata_p, e[23:16], e[15:0]);
                end
            end
        end
        if (res_wr_en_s === 1'b1) begin
            checks++;
            if (exp_qs.size() == 0) begin
                errors++;
                $display("FAIL stride_write_unexpected: got addr=%0d data=%h, required no write", addr_s, wdata_s);
            end else begin
                e = exp_qs.pop_front();
                if ({addr_s, wdata_s} !== e) begin
                    errors++;
                    $display("FAIL stride_write: got addr=%0d data=%h, required addr=%0d data=%h",
                             addr_s, wdata_s, e[23:16], e[15:0]);
                end
            end
        end
    end

    task automatic test_reset;
        reset = 1'b1; start = 1'b1; abort = 1'b1; win_ready = 1'b0; res_valid = 1'b1;
        start_p = 1'b0; start_s = 1'b0; data_base = 16'h0000;
        repeat (2) @(negedge clk);
        checks++;
        if ({conv_en, anchor_2D, anchor_1D, win_valid, res_wr_en, res_addr, res_wdata, busy, done, protocol_err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h, required 0",
                     {conv_en, anchor_2D, anchor_1D, win_valid, res_wr_en, res_addr, res_wdata, busy, done, protocol_err});
        end
        reset = 1'b0; start = 1'b0; abort = 1'b0; res_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, conv_en, protocol_err} !== 3'b000) begin
            errors++;
            $display("FAIL reset_idle: got busy/conv_en/err=%b, required 000", {busy, conv_en, protocol_err});
        end
    endtask

    task automatic test_protocol;
        checks++;
        if (protocol_err !== 1'b0) begin
            errors++;
            $display("FAIL perr_initial: got %b, required 0", protocol_err);
        end
        res_valid = 1'b1;
        @(negedge clk);
        res_valid = 1'b0;
        checks++;
        if ({protocol_err, res_wr_en, busy} !== 3'b100) begin
            errors++;
            $display("FAIL perr_set: got err/wr/busy=%b, required 100", {protocol_err, res_wr_en, busy});
        end
        anc_q.push_back(32'h0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if ({protocol_err, busy} !== 2'b01) begin
            errors++;
            $display("FAIL perr_clear: got err/busy=%b, required 01", {protocol_err, busy});
        end
        repeat (2) @(negedge clk);
        checks++;
        if (win_valid !== 1'b1) begin
            errors++;
            $display("FAIL issue_before_reset: got win_valid=%b, required 1", win_valid);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if ({conv_en, anchor_2D, anchor_1D, win_valid, res_wr_en, res_addr, res_wdata, busy, done, protocol_err} !== '0) begin
            errors++;
            $display("FAIL reset_mid_issue: got %h, required 0",
                     {conv_en, anchor_2D, anchor_1D, win_valid, res_wr_en, res_addr, res_wdata, busy, done, protocol_err});
        end
        anc_q.delete();
    endtask

    task automatic test_basic;
        int n;
        data_base = 16'h0A00; win_ready = 1'b1; res_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back({8'(k), 16'h0A00 + 16'(k)});
            anc_q.push_back({16'(k / 2), 16'(k % 2)});
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if ({busy, conv_en, win_valid, anchor_2D, anchor_1D} !== {3'b110, 32'h0}) begin
            errors++;
            $display("FAIL setup_state: got busy/conv_en/win_valid=%b anchors (%0d,%0d), required 110 (0,0)",
                     {busy, conv_en, win_valid}, anchor_2D, anchor_1D);
        end
        n = 1;
        while (done !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        // 18 cycles counted inclusively from the start-sampling cycle to the DONE cycle
        checks++;
        if (n != 17) begin
            errors++;
            $display("FAIL done_latency: got %0d edges after start sample, required 17", n);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if ({done, busy, conv_en} !== 3'b000) begin
            errors++;
            $display("FAIL start_in_done: got done/busy/conv_en=%b, required 000", {done, busy, conv_en});
        end
        checks++;
        if (exp_q.size() != 0 || anc_q.size() != 0) begin
            errors++;
            $display("FAIL basic_drain: got %0d writes / %0d windows outstanding, required 0/0", exp_q.size(), anc_q.size());
        end
    endtask

    task automatic test_backpressure;
        int base, cyc;
        data_base = 16'h0B00; win_ready = 1'b1; res_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back({8'(k), 16'h0B00 + 16'(k)});
            anc_q.push_back({16'(k / 2), 16'(k % 2)});
        end
        base = wr_count;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!(wr_count == base + 1 && win_valid === 1'b1) && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cyc >= 40) begin
            errors++;
            $display("FAIL bp_window2: got no second window within 40 cycles, required one");
        end
        win_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({win_valid, conv_en, res_wr_en} !== 3'b110) begin
                errors++;
                $display("FAIL bp_hold: got valid/en/wr=%b, required 110", {win_valid, conv_en, res_wr_en});
            end
        end
        win_ready = 1'b1;
        res_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({win_valid, conv_en, res_wr_en} !== 3'b010) begin
                errors++;
                $display("FAIL bp_wait: got valid/en/wr=%b, required 010", {win_valid, conv_en, res_wr_en});
            end
        end
        res_valid = 1'b1;
        @(negedge clk);
        checks++;
        if ({res_wr_en, res_addr, res_wdata} !== {1'b1, 8'd1, 16'h0B01}) begin
            errors++;
            $display("FAIL bp_write: got wr=%b addr=%0d data=%h, required 1 1 0b01", res_wr_en, res_addr, res_wdata);
        end
        cyc = 0;
        while (done !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        @(negedge clk);
        checks++;
        if (cyc >= 40 || exp_q.size() != 0 || anc_q.size() != 0) begin
            errors++;
            $display("FAIL bp_complete: got wait=%0d outstanding=%0d/%0d, required done and 0/0",
                     cyc, exp_q.size(), anc_q.size());
        end
    endtask

    task automatic test_abort;
        int base, cyc;
        logic done_seen;
        data_base = 16'h0C00; win_ready = 1'b1; res_valid = 1'b1;
        for (int k = 0; k < 2; k++) exp_q.push_back({8'(k), 16'h0C00 + 16'(k)});
        for (int k = 0; k < 3; k++) anc_q.push_back({16'(k / 2), 16'(k % 2)});
        base = wr_count;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (wr_count != base + 2 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        res_valid = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({win_valid, conv_en, busy, anchor_2D, anchor_1D} !== {3'b011, 16'd1, 16'd0}) begin
            errors++;
            $display("FAIL abort_wait_state: got valid/en/busy=%b anchors (%0d,%0d), required 011 (1,0)",
                     {win_valid, conv_en, busy}, anchor_2D, anchor_1D);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if ({conv_en, anchor_2D, anchor_1D, win_valid, res_wr_en, res_addr, res_wdata, busy, done} !== '0) begin
            errors++;
            $display("FAIL abort_outputs: got %h, required 0",
                     {conv_en, anchor_2D, anchor_1D, win_valid, res_wr_en, res_addr, res_wdata, busy, done});
        end
        done_seen = 1'b0;
        res_valid = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) done_seen = 1'b1;
        end
        checks++;
        if (done_seen !== 1'b0 || exp_q.size() != 0 || anc_q.size() != 0) begin
            errors++;
            $display("FAIL abort_quiet: got done/busy activity=%b outstanding=%0d/%0d, required 0 0/0",
                     done_seen, exp_q.size(), anc_q.size());
        end
        data_base = 16'h0D00;
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back({8'(k), 16'h0D00 + 16'(k)});
            anc_q.push_back({16'(k / 2), 16'(k % 2)});
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (done !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cyc >= 40 || exp_q.size() != 0 || anc_q.size() != 0) begin
            errors++;
            $display("FAIL abort_rerun: got wait=%0d outstanding=%0d/%0d, required done and 0/0",
                     cyc, exp_q.size(), anc_q.size());
        end
        @(negedge clk);
    endtask

    task automatic test_padding;
        int dones;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                exp_qp.push_back({8'(r * 4 + c), 8'(r), 8'(c)});
        start_p = 1'b1;
        @(negedge clk);
        start_p = 1'b0;
        dones = 0;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if (done_p === 1'b1) dones++;
        end
        checks++;
        if (dones != 1 || exp_qp.size() != 0 || last_addr_p !== 8'd15) begin
            errors++;
            $display("FAIL pad_map: got dones=%0d outstanding=%0d last_addr=%0d, required 1 0 15",
                     dones, exp_qp.size(), last_addr_p);
        end
        checks++;
        if ({busy_p, conv_en_p, win_valid_p, res_wr_en_p, perr_p} !== 5'b00001) begin
            errors++;
            $display("FAIL pad_idle: got busy/en/valid/wr/err=%b, required 00001",
                     {busy_p, conv_en_p, win_valid_p, res_wr_en_p, perr_p});
        end
    endtask

    task automatic test_stride;
        int dones;
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++)
                exp_qs.push_back({8'(r * 2 + c), 8'(r * 2), 8'(c * 2)});
        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done_s === 1'b1) dones++;
        end
        checks++;
        if (dones != 1 || exp_qs.size() != 0) begin
            errors++;
            $display("FAIL stride_map: got dones=%0d outstanding=%0d, required 1 0", dones, exp_qs.size());
        end
        checks++;
        if ({busy_s, conv_en_s, win_valid_s, res_wr_en_s, perr_s} !== 5'b00001) begin
            errors++;
            $display("FAIL stride_idle: got busy/en/valid/wr/err=%b, required 00001",
                     {busy_s, conv_en_s, win_valid_s, res_wr_en_s, perr_s});
        end
    endtask

    initial begin
        last_addr_p = 8'h00;
        test_reset();
        test_protocol();
        test_basic();
        test_backpressure();
        test_abort();
        test_padding();
        test_stride();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/conv_window_scheduler.md
Name: conv_window_scheduler

Overview:
- Sequences the convolution window buffer over one full output feature map.
- Each step it drives conv_en and the anchor_2D/anchor_1D window position, then hands the window to the downstream multiply-accumulate stage over a valid/ready handshake.
- It waits for that stage's scalar result and writes it to the result memory at the row-major output address.
- Exactly one window is in flight at any time.

Parameters:
data_width, 16, width of anchors and result data
image_length, 4, input columns (1D extent)
image_width, 4, input rows (2D extent)
weight_length, 3, kernel columns
weight_width, 3, kernel rows
stride, 1, anchor step in both dimensions (>=1)
padding, 0, zero border applied on each side
result_length, (image_length+2*padding-weight_length)/stride+1, output columns
result_width, (image_width+2*padding-weight_width)/stride+1, output rows
addr_width, 8, result address width; must satisfy 2^addr_width >= result_length*result_width

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
start  in  1  begin one feature map; sampled only in IDLE
abort  in  1  return to IDLE next cycle from any state
conv_en  out  1  enable to window buffer
anchor_2D  out  data_width  window top row, padded coordinates
anchor_1D  out  data_width  window left column, padded coordinates
win_valid  out  1  current window is presented downstream
win_ready  in  1  downstream accepts window
res_valid  in  1  downstream result strobe
res_data  in  data_width  downstream result value
res_wr_en  out  1  result memory write strobe
res_addr  out  addr_width  result memory address = row*result_length+col
res_wdata  out  data_width  result memory write data
busy  out  1  high from start acceptance until DONE
done  out  1  one-cycle pulse on completion
protocol_err  out  1  sticky: res_valid seen outside WAIT; cleared on accepted start

Behaviour:
- Reset (clk edge with reset=1):
  - State is IDLE.
  - All outputs are 0 and all counters are 0.
  - Reset wins over start and abort in the same cycle. Reset mid-map discards all progress; no write is issued.
- States: IDLE, SETUP, ISSUE, WAIT, WRITE, DONE.
- IDLE:
  - start=1 leads to SETUP next cycle.
  - row, col, anchor_2D, anchor_1D and protocol_err are cleared; busy goes to 1.
- SETUP:
  - conv_en=1 and anchors stable.
  - Lasts exactly one cycle so the buffer output settles, then goes to ISSUE.
- ISSUE:
  - win_valid=1, with anchors and conv_en held.
  - A cycle with win_ready=1 is the transfer; state goes to WAIT next cycle.
  - There is no timeout.
- WAIT:
  - win_valid=0 and conv_en stays 1.
  - The first cycle with res_valid=1 captures res_data, then goes to WRITE.
  - res_valid in the same cycle as the ISSUE transfer is not accepted and sets protocol_err.
- WRITE (one cycle):
  - res_wr_en=1, res_addr=row*result_length+col, res_wdata=captured value.
  - Advance: if col<result_length-1 then col+1; else col=0 and row+1.
  - Anchors are recomputed as anchor_1D=col*stride and anchor_2D=row*stride (registered, no multiplier: accumulate stride).
  - If the pair written was the last one (row=result_width-1, col=result_length-1), go to DONE; else go to SETUP.
- DONE:
  - done=1 for one cycle, busy=0, conv_en=0, anchors reset to 0.
  - Goes to IDLE. A start during DONE is ignored.
- Cycle budget with zero-latency handshakes:
  - Per window: SETUP 1 + ISSUE 1 + WAIT ≥1 + WRITE 1 = 4 cycles minimum.
  - Per map: 4*result_length*result_width + 2 cycles from start to done, inclusive of the IDLE sample and DONE.
- abort:
  - Any state other than IDLE goes to IDLE next cycle with all outputs 0.
  - An in-progress WRITE cycle still completes its write; abort takes effect afterwards.
  - done is not pulsed.
- protocol_err is set by res_valid in IDLE, SETUP, ISSUE, WRITE or DONE. Those results are otherwise ignored.
- win_valid must not drop in ISSUE before the transfer. Anchors and conv_en must be stable from SETUP through WAIT.
- Anchor widths: zero-extended counters. Assertion: (result_width-1)*stride < 2^data_width.

Test Plan:
- Defaults (4x4, 3x3, stride 1, pad 0), win_ready and res_valid tied high, res_data=0x0A00+addr → anchors (2D,1D) (0,0),(0,1),(1,0),(1,1); writes addr 0..3 with 0x0A00..0x0A03; done pulses 18 cycles after start sampled; busy low after.
- padding=1 (result 4x4) → 16 writes, anchors step 0..3 in both dims, last write addr 15, done once.
- image 5x5, stride=2 (result 2x2) → anchor values {0,2} only, addresses 0,1,2,3 in order.
- Backpressure: win_ready low 5 cycles on window 2, res_valid delayed 3 cycles → win_valid held with anchors (0,1) unchanged; no write until res_valid; data correct.
- abort asserted in WAIT of window 3 → IDLE next cycle, no further res_wr_en, no done; a subsequent start reruns from anchor (0,0).
- res_valid pulsed in IDLE → protocol_err=1 and no write; next start clears it. reset asserted mid-ISSUE → all outputs 0 next cycle.
